// File: rtl/dma_arb_pkg.sv
// dma_arb_pkg
//   Shared definitions for the DMA priority arbiter:
//     - NUM_CH                 : number of DMA channels (4)
//     - CMD_* constants        : bit positions inside commandReg
//     - arb_state_e            : one-hot arbiter states (IDLE, REQ, SERVICE)
//     - pick_winner()          : round-robin search helper
package dma_arb_pkg;

  localparam int NUM_CH = 4;

  localparam int CMD_DISABLE   = 2;
  localparam int CMD_ROTATE    = 4;
  localparam int CMD_DREQ_LOW  = 6;
  localparam int CMD_DACK_HIGH = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_REQ     = 3'b010,
    ST_SERVICE = 3'b100
  } arb_state_e;

  // Return the first set bit of req, searching upward from start and
  // wrapping modulo 4. When req is empty the result is start; callers only
  // use it when at least one bit is set.
  function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                             input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = start;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/dma_priority_arbiter_sync.sv
// dma_dreq_sync
//   Shift-register synchronizer for the four raw DREQ lines. DEPTH sets the
//   number of flops between the asynchronous input and q.
//   Ports:
//     CLK   in  1  clock
//     RESET in  1  asynchronous active-high reset, clears every stage
//     d     in  4  raw, asynchronous request lines
//     q     out 4  synchronized request lines
module dma_dreq_sync #(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] stages [DEPTH];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
//   Four-channel DMA request arbiter with fixed or rotating priority.
//   The one-hot FSM (IDLE -> REQ -> SERVICE) latches a winner, presents it
//   on VALID_DREQ, waits for HLDA and drives DACK during the dackEn window.
//
//   Build option: define DMA_DREQ_SYNC_EN for a 2-flop DREQ synchronizer
//   (DREQ -> VALID_DREQ = 3 edges); default is a single register (2 edges).
//
//   Handshake: a grant is offered on VALID_DREQ from the cycle after
//   arbitration; it is held until HLDA moves the FSM into SERVICE, or
//   withdrawn if its request drops before HLDA. In SERVICE, serviceDone or
//   loss of HLDA ends the transfer and clears VALID_DREQ.
//
//   Ports:
//     CLK          in  1  clock
//     RESET        in  1  asynchronous active-high reset
//     DREQ         in  4  raw channel requests (asynchronous)
//     maskReg      in  4  per-channel mask, 1 = masked
//     requestReg   in  4  software requests, never masked
//     commandReg   in  8  bit2 disable, bit4 rotate, bit6 DREQ low, bit7 DACK high
//     HLDA         in  1  hold acknowledge
//     dackEn       in  1  DACK window strobe
//     serviceDone  in  1  end-of-transfer pulse
//     VALID_DREQ   out 4  one-hot granted request
//     DACK         out 4  channel acknowledges, polarity from commandReg[7]
//     grantCh      out 2  granted channel index
module dma_priority_arbiter
  import dma_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic [3:0] maskReg,
  input  logic [3:0] requestReg,
  input  logic [7:0] commandReg,
  input  logic       HLDA,
  input  logic       dackEn,
  input  logic       serviceDone,
  output logic [3:0] VALID_DREQ,
  output logic [3:0] DACK,
  output logic [1:0] grantCh
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_REQ     = ST_REQ;
  localparam logic [2:0] S_SERVICE = ST_SERVICE;

`ifdef DMA_DREQ_SYNC_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

  logic [2:0] state;
  logic [1:0] ptr;
  logic [3:0] sync_dreq;
  logic [3:0] dreq_pol;
  logic [3:0] eff;
  logic [1:0] search_start;
  logic [1:0] winner;
  logic [3:0] dack_active;
  logic       rotate;

  // Bits of commandReg that this block does not interpret.
  logic unused_cmd;
  assign unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

  dma_dreq_sync #(
    .DEPTH (SYNC_DEPTH)
  ) u_sync (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (DREQ),
    .q     (sync_dreq)
  );

  assign rotate = commandReg[CMD_ROTATE];

  always_comb begin
    dreq_pol     = sync_dreq ^ {NUM_CH{commandReg[CMD_DREQ_LOW]}};
    eff          = commandReg[CMD_DISABLE] ? 4'b0000
                                           : ((dreq_pol & ~maskReg) | requestReg);
    // With fixed priority the search always starts at channel 0.
    search_start = rotate ? ptr : 2'd0;
    winner       = pick_winner(eff, search_start);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      ptr        <= 2'd0;
      grantCh    <= 2'd0;
      VALID_DREQ <= 4'b0000;
    end else begin
      if (!rotate) begin
        ptr <= 2'd0;
      end
      case (state)
        S_IDLE: begin
          if (|eff) begin
            grantCh    <= winner;
            VALID_DREQ <= 4'b0001 << winner;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          // The grant is frozen here; HLDA wins over a simultaneous drop.
          if (HLDA) begin
            state <= S_SERVICE;
          end else if (!eff[grantCh]) begin
            state      <= S_IDLE;
            VALID_DREQ <= 4'b0000;
          end
        end
        S_SERVICE: begin
          // Disable does not abort a transfer already in progress.
          if (serviceDone || !HLDA) begin
            state      <= S_IDLE;
            VALID_DREQ <= 4'b0000;
            if (rotate) begin
              ptr <= grantCh + 2'd1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          VALID_DREQ <= 4'b0000;
        end
      endcase
    end
  end

  // DACK follows registered state directly so an asynchronous reset drops
  // it immediately, without a clock edge.
  always_comb begin
    dack_active = 4'b0000;
    if (state == S_SERVICE && dackEn) begin
      dack_active = 4'b0001 << grantCh;
    end
    DACK = {NUM_CH{~commandReg[CMD_DACK_HIGH]}} ^ dack_active;
  end

endmodule
